// File: rtl/hawk_tbl_updt_mngr.sv
// hawk_tbl_updt_mngr
// Commits one page allocation at a time: writes the 64-bit ATT entry for the
// allocated hppa with a single strobed AXI beat, optionally zeroes the popped
// free-list entry, then advances the free-list head and pulses done.
// Optional feature macro: HAWK_TBL_UPDT_LST_CLR_EN (clears the popped list
// entry with a second AXI write before completing).
module hawk_tbl_updt_mngr #(
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
    parameter logic [47:0] HAWK_LIST_START = 48'h0000_2000_0000,
`endif
    parameter logic [47:0] HAWK_ATT_START  = 48'h0000_1000_0000,
    parameter logic [47:0] HPPA_BASE_ADDR  = 48'h0000_0010_0000,
    parameter int unsigned LST_ENTRY_MAX   = 64,
    parameter int unsigned LST_HEAD_RST    = 1,
    localparam int unsigned LW             = $clog2(LST_ENTRY_MAX)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          updt_req_i,
    output logic          updt_rdy_o,
    input  logic [47:0]   hppa_i,
    input  logic [47:0]   ppa_i,
    input  logic [LW-1:0] nxt_head_i,
    output logic [47:0]   awaddr_o,
    output logic          awvalid_o,
    input  logic          awready_i,
    output logic [511:0]  wdata_o,
    output logic [63:0]   wstrb_o,
    output logic          wlast_o,
    output logic          wvalid_o,
    input  logic          wready_i,
    input  logic [1:0]    bresp_i,
    input  logic          bvalid_i,
    output logic          bready_o,
    output logic [LW-1:0] free_lst_head_o,
    output logic          updt_done_o,
    output logic          updt_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATT_WR  = 3'd1,
        ST_ATT_RSP = 3'd2,
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
        ST_LST_WR  = 3'd3,
        ST_LST_RSP = 3'd4,
`endif
        ST_DONE    = 3'd5
    } state_t;

    // ATT entry: valid + uncompressed marker on top, ppa in the low 48 bits.
    function automatic logic [63:0] att_entry(input logic [47:0] ppa);
        att_entry = {2'b01, 14'd0, ppa};
    endfunction

    // 64B line holding the entry: eight 8-byte entries per line.
    function automatic logic [47:0] att_line_addr(input logic [44:0] idx);
        att_line_addr = HAWK_ATT_START + {idx[44:3], 6'd0};
    endfunction

    // Place the entry in its 64-bit lane; all other lanes are zero.
    function automatic logic [511:0] att_wdata(input logic [63:0] entry, input logic [2:0] lane);
        att_wdata = {448'd0, entry} << {lane, 6'd0};
    endfunction

    function automatic logic [63:0] att_strb(input logic [2:0] lane);
        att_strb = 64'h0000_0000_0000_00FF << {lane, 3'd0};
    endfunction

`ifdef HAWK_TBL_UPDT_LST_CLR_EN
    // List entries are 16B, four per 64B line; list index 1 is the first slot.
    function automatic logic [47:0] lst_line_addr(input logic [LW-1:0] pop_idx);
        logic [LW-1:0] slot;
        slot          = pop_idx - LW'(1);
        lst_line_addr = HAWK_LIST_START + 48'({slot[LW-1:2], 6'd0});
    endfunction

    function automatic logic [63:0] lst_strb(input logic [LW-1:0] pop_idx);
        logic [LW-1:0] slot;
        slot     = pop_idx - LW'(1);
        lst_strb = 64'h0000_0000_0000_FFFF << {slot[1:0], 4'd0};
    endfunction
`endif

    state_t         state_r;
    state_t         state_nxt_s;
    logic [44:0]    idx_s;
    logic           aw_ok_s;
    logic           w_ok_s;
    logic           b_hs_s;

    logic           rdy_r;
    logic [47:0]    awaddr_r,   awaddr_nxt_s;
    logic           awvalid_r,  awvalid_nxt_s;
    logic [511:0]   wdata_r,    wdata_nxt_s;
    logic [63:0]    wstrb_r,    wstrb_nxt_s;
    logic           wvalid_r,   wvalid_nxt_s;
    logic           bready_r,   bready_nxt_s;
    logic [LW-1:0]  head_r,     head_nxt_s;
    logic [LW-1:0]  nxt_head_r, nxt_head_nxt_s;
    logic           done_r,     done_nxt_s;
    logic           err_r,      err_nxt_s;
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
    logic [LW-1:0]  pop_idx_r,  pop_idx_nxt_s;
`endif

    // Only idx bits [44:3] reach the line address after the <<6, so 45 bits suffice.
    assign idx_s   = 45'(hppa_i - HPPA_BASE_ADDR);
    // A channel is finished once its beat has been taken (now or earlier).
    assign aw_ok_s = ~awvalid_r | awready_i;
    assign w_ok_s  = ~wvalid_r  | wready_i;
    assign b_hs_s  = bvalid_i & bready_r;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (updt_req_i) state_nxt_s = ST_ATT_WR;
                else            state_nxt_s = ST_IDLE;
            end
            ST_ATT_WR: begin
                if (aw_ok_s && w_ok_s) state_nxt_s = ST_ATT_RSP;
                else                   state_nxt_s = ST_ATT_WR;
            end
            ST_ATT_RSP: begin
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
                if (b_hs_s) state_nxt_s = ST_LST_WR;
                else        state_nxt_s = ST_ATT_RSP;
`else
                if (b_hs_s) state_nxt_s = ST_DONE;
                else        state_nxt_s = ST_ATT_RSP;
`endif
            end
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
            ST_LST_WR: begin
                if (aw_ok_s && w_ok_s) state_nxt_s = ST_LST_RSP;
                else                   state_nxt_s = ST_LST_WR;
            end
            ST_LST_RSP: begin
                if (b_hs_s) state_nxt_s = ST_DONE;
                else        state_nxt_s = ST_LST_RSP;
            end
`endif
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and request context.
    always_comb begin
        awaddr_nxt_s   = awaddr_r;
        awvalid_nxt_s  = awvalid_r;
        wdata_nxt_s    = wdata_r;
        wstrb_nxt_s    = wstrb_r;
        wvalid_nxt_s   = wvalid_r;
        head_nxt_s     = head_r;
        nxt_head_nxt_s = nxt_head_r;
        done_nxt_s     = 1'b0;
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
        pop_idx_nxt_s  = pop_idx_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (updt_req_i) begin
                    awvalid_nxt_s  = 1'b1;
                    wvalid_nxt_s   = 1'b1;
                    awaddr_nxt_s   = att_line_addr(idx_s);
                    wdata_nxt_s    = att_wdata(att_entry(ppa_i), idx_s[2:0]);
                    wstrb_nxt_s    = att_strb(idx_s[2:0]);
                    nxt_head_nxt_s = nxt_head_i;
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
                    pop_idx_nxt_s  = head_r;
`endif
                end else begin
                    awvalid_nxt_s  = 1'b0;
                    wvalid_nxt_s   = 1'b0;
                end
            end
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
            ST_ATT_WR, ST_LST_WR: begin
`else
            ST_ATT_WR: begin
`endif
                awvalid_nxt_s = awvalid_r & ~awready_i;
                wvalid_nxt_s  = wvalid_r  & ~wready_i;
            end
            ST_ATT_RSP: begin
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
                if (b_hs_s) begin
                    awvalid_nxt_s = 1'b1;
                    wvalid_nxt_s  = 1'b1;
                    awaddr_nxt_s  = lst_line_addr(pop_idx_r);
                    wdata_nxt_s   = 512'd0;
                    wstrb_nxt_s   = lst_strb(pop_idx_r);
                end else begin
                    awvalid_nxt_s = 1'b0;
                    wvalid_nxt_s  = 1'b0;
                end
`else
                awvalid_nxt_s = 1'b0;
                wvalid_nxt_s  = 1'b0;
`endif
            end
            ST_DONE: begin
                head_nxt_s = nxt_head_r;
                done_nxt_s = 1'b1;
            end
            default: begin
                awvalid_nxt_s = 1'b0;
                wvalid_nxt_s  = 1'b0;
            end
        endcase
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
        bready_nxt_s = (state_nxt_s == ST_ATT_RSP) || (state_nxt_s == ST_LST_RSP);
`else
        bready_nxt_s = (state_nxt_s == ST_ATT_RSP);
`endif
        // A bad response is remembered but never aborts the request.
        err_nxt_s = err_r | (b_hs_s & (bresp_i != 2'b00));
    end

    // Output and context registers; reset drops every valid immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_r      <= 1'b1;
            awaddr_r   <= 48'd0;
            awvalid_r  <= 1'b0;
            wdata_r    <= 512'd0;
            wstrb_r    <= 64'd0;
            wvalid_r   <= 1'b0;
            bready_r   <= 1'b0;
            head_r     <= LW'(LST_HEAD_RST);
            nxt_head_r <= {LW{1'b0}};
            done_r     <= 1'b0;
            err_r      <= 1'b0;
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
            pop_idx_r  <= {LW{1'b0}};
`endif
        end else begin
            rdy_r      <= (state_nxt_s == ST_IDLE);
            awaddr_r   <= awaddr_nxt_s;
            awvalid_r  <= awvalid_nxt_s;
            wdata_r    <= wdata_nxt_s;
            wstrb_r    <= wstrb_nxt_s;
            wvalid_r   <= wvalid_nxt_s;
            bready_r   <= bready_nxt_s;
            head_r     <= head_nxt_s;
            nxt_head_r <= nxt_head_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
            pop_idx_r  <= pop_idx_nxt_s;
`endif
        end
    end

    assign updt_rdy_o      = rdy_r;
    assign awaddr_o        = awaddr_r;
    assign awvalid_o       = awvalid_r;
    assign wdata_o         = wdata_r;
    assign wstrb_o         = wstrb_r;
    assign wvalid_o        = wvalid_r;
    assign wlast_o         = wvalid_r;
    assign bready_o        = bready_r;
    assign free_lst_head_o = head_r;
    assign updt_done_o     = done_r;
    assign updt_err_o      = err_r;

endmodule

// File: tb/tb_hawk_tbl_updt_mngr.sv
// Directed bench for hawk_tbl_updt_mngr with a small AXI write slave driven
// from the request task. Builds with or without HAWK_TBL_UPDT_LST_CLR_EN.
`timescale 1ns/1ps
module tb_hawk_tbl_updt_mngr;
    localparam int LW = 6;
    localparam logic [47:0] ATT  = 48'h0000_1000_0000;
    localparam logic [47:0] BASE = 48'h0000_0010_0000;
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
    localparam logic [47:0] LST  = 48'h0000_2000_0000;
    localparam int N_WR = 2;
    localparam int LAT  = 6;
`else
    localparam int N_WR = 1;
    localparam int LAT  = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          updt_req_i = 1'b0;
    logic          updt_rdy_o;
    logic [47:0]   hppa_i = 48'd0;
    logic [47:0]   ppa_i = 48'd0;
    logic [LW-1:0] nxt_head_i = 6'd0;
    logic [47:0]   awaddr_o;
    logic          awvalid_o;
    logic          awready_i = 1'b1;
    logic [511:0]  wdata_o;
    logic [63:0]   wstrb_o;
    logic          wlast_o;
    logic          wvalid_o;
    logic          wready_i = 1'b1;
    logic [1:0]    bresp_i = 2'b00;
    logic          bvalid_i = 1'b0;
    logic          bready_o;
    logic [LW-1:0] free_lst_head_o;
    logic          updt_done_o;
    logic          updt_err_o;

    int checks = 0;
    int failures = 0;

    // Observations gathered by do_req.
    logic [47:0]  cap_addr [2];
    logic [511:0] cap_data [2];
    logic [63:0]  cap_strb [2];
    int aw_hi, w_hi, aw_hs_n, w_hs_n, done_n, done_cyc, unstable, wlast_bad, timeout;

    hawk_tbl_updt_mngr dut (
        .clk_i(clk), .rst_ni(rst_ni), .updt_req_i(updt_req_i), .updt_rdy_o(updt_rdy_o),
        .hppa_i(hppa_i), .ppa_i(ppa_i), .nxt_head_i(nxt_head_i),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
        .wready_i(wready_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .free_lst_head_o(free_lst_head_o), .updt_done_o(updt_done_o), .updt_err_o(updt_err_o)
    );

    always #5 clk = ~clk;

    // One request plus slave responses; aw_dly/w_dly stall only the ATT beat,
    // resp is returned only on the ATT write.
    task automatic do_req(input logic [47:0] hppa, input logic [47:0] ppa, input logic [LW-1:0] nh,
                          input int aw_dly, input int w_dly, input logic [1:0] resp);
        int  cyc, wr_n, aw_cnt, w_cnt;
        bit  aw_hs, w_hs, b_hs, aw_done, w_done, b_sent, aw_seen, w_seen, fin;
        logic [47:0]  aw_first;
        logic [511:0] w_first;
        aw_hi = 0; w_hi = 0; aw_hs_n = 0; w_hs_n = 0; done_n = 0; done_cyc = -1;
        unstable = 0; wlast_bad = 0; timeout = 0;
        for (int i = 0; i < 2; i++) begin
            cap_addr[i] = 48'hDEAD; cap_data[i] = {512{1'b1}}; cap_strb[i] = 64'd0;
        end
        cyc = 0; wr_n = 0; aw_cnt = 0; w_cnt = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; aw_done = 0; w_done = 0; b_sent = 0;
        aw_seen = 0; w_seen = 0; fin = 0; aw_first = 48'd0; w_first = 512'd0;
        @(negedge clk);
        hppa_i = hppa; ppa_i = ppa; nxt_head_i = nh; updt_req_i = 1'b1;
        awready_i = (aw_dly == 0); wready_i = (w_dly == 0);
        while (!fin) begin
            @(negedge clk);
            cyc++;
            updt_req_i = 1'b0;
            if (b_hs) begin
                bvalid_i = 1'b0; bresp_i = 2'b00; b_hs = 0;
                aw_done = 0; w_done = 0; b_sent = 0; wr_n++;
            end
            if (aw_hs) begin aw_done = 1; aw_hs = 0; end
            if (w_hs)  begin w_done = 1;  w_hs = 0;  end
            if (aw_done && w_done && !b_sent) begin
                bvalid_i = 1'b1; bresp_i = (wr_n == 0) ? resp : 2'b00; b_sent = 1;
            end
            if (bvalid_i && bready_o) b_hs = 1;
            if (awvalid_o) begin
                if (wr_n == 0) aw_hi++;
                if (!aw_seen) begin aw_seen = 1; aw_first = awaddr_o; end
                else if (awaddr_o !== aw_first) unstable++;
                awready_i = (wr_n != 0) || (aw_cnt >= aw_dly);
                aw_cnt++;
                if (awready_i) begin
                    aw_hs = 1; aw_hs_n++; aw_seen = 0; aw_cnt = 0;
                    if (wr_n < 2) cap_addr[wr_n] = awaddr_o;
                end
            end else begin
                awready_i = (aw_dly == 0);
            end
            if (wvalid_o) begin
                if (wr_n == 0) w_hi++;
                if (!wlast_o) wlast_bad++;
                if (!w_seen) begin w_seen = 1; w_first = wdata_o; end
                else if (wdata_o !== w_first) unstable++;
                wready_i = (wr_n != 0) || (w_cnt >= w_dly);
                w_cnt++;
                if (wready_i) begin
                    w_hs = 1; w_hs_n++; w_seen = 0; w_cnt = 0;
                    if (wr_n < 2) begin cap_data[wr_n] = wdata_o; cap_strb[wr_n] = wstrb_o; end
                end
            end else begin
                wready_i = (w_dly == 0);
            end
            if (updt_done_o) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1;
            if (cyc >= 60) begin timeout = 1; fin = 1; end
        end
        awready_i = 1'b1; wready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (updt_rdy_o !== 1'b1) begin failures++; $display("FAIL rst_rdy got=%b exp=1", updt_rdy_o); end
        checks++; if (free_lst_head_o !== 6'd1) begin failures++; $display("FAIL rst_head got=%0d exp=1", free_lst_head_o); end
        checks++; if ({awvalid_o, wvalid_o, bready_o, updt_done_o} !== 4'b0000) begin failures++; $display("FAIL rst_valids got=%b exp=0000", {awvalid_o, wvalid_o, bready_o, updt_done_o}); end
        checks++; if (updt_err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", updt_err_o); end
        checks++; if (awaddr_o !== 48'd0 || wstrb_o !== 64'd0 || wdata_o !== 512'd0) begin failures++; $display("FAIL rst_payload addr=%h strb=%h", awaddr_o, wstrb_o); end
    endtask

    task automatic test_basic();
        logic [511:0] exp_d;
        exp_d = 512'd0;
        exp_d[127:64] = 64'h4000_0000_0000_0ABC;
        do_req(BASE + 48'd9, 48'hABC, 6'd2, 0, 0, 2'b00);
        checks++; if (timeout !== 0) begin failures++; $display("FAIL basic_timeout got=%0d exp=0", timeout); end
        checks++; if (cap_addr[0] !== ATT + 48'h40) begin failures++; $display("FAIL basic_addr got=%h exp=%h", cap_addr[0], ATT + 48'h40); end
        checks++; if (cap_strb[0] !== 64'h0000_0000_0000_FF00) begin failures++; $display("FAIL basic_strb got=%h exp=ff00", cap_strb[0]); end
        checks++; if (cap_data[0] !== exp_d) begin failures++; $display("FAIL basic_data got=%h exp=%h", cap_data[0], exp_d); end
        checks++; if (done_n !== 1) begin failures++; $display("FAIL basic_done_cnt got=%0d exp=1", done_n); end
        checks++; if (done_cyc !== LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", done_cyc, LAT); end
        checks++; if (free_lst_head_o !== 6'd2) begin failures++; $display("FAIL basic_head got=%0d exp=2", free_lst_head_o); end
        checks++; if (aw_hs_n !== N_WR || w_hs_n !== N_WR) begin failures++; $display("FAIL basic_beats aw=%0d w=%0d exp=%0d", aw_hs_n, w_hs_n, N_WR); end
        checks++; if (aw_hi !== 1 || w_hi !== 1) begin failures++; $display("FAIL basic_valid_len aw=%0d w=%0d exp=1", aw_hi, w_hi); end
        checks++; if (wlast_bad !== 0) begin failures++; $display("FAIL basic_wlast got=%0d exp=0", wlast_bad); end
        checks++; if (updt_err_o !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", updt_err_o); end
    endtask

    task automatic test_lanes();
        logic [47:0]   v_hppa [3];
        logic [47:0]   v_ppa  [3];
        logic [LW-1:0] v_nh   [3];
        logic [47:0]   v_addr [3];
        logic [63:0]   v_strb [3];
        int            v_lane [3];
        logic [511:0]  exp_d;
        v_hppa[0] = BASE;            v_ppa[0] = 48'h1234_5678_9ABC; v_nh[0] = 6'd0;
        v_addr[0] = ATT;             v_strb[0] = 64'h0000_0000_0000_00FF; v_lane[0] = 0;
        v_hppa[1] = BASE + 48'd15;   v_ppa[1] = 48'hFFFF_FFFF_FFFF; v_nh[1] = 6'd63;
        v_addr[1] = ATT + 48'h40;    v_strb[1] = 64'hFF00_0000_0000_0000; v_lane[1] = 7;
        v_hppa[2] = BASE - 48'd1;    v_ppa[2] = 48'h5;              v_nh[2] = 6'd5;
        v_addr[2] = 48'h0000_0FFF_FFC0; v_strb[2] = 64'hFF00_0000_0000_0000; v_lane[2] = 7;
        for (int i = 0; i < 3; i++) begin
            exp_d = 512'd0;
            exp_d[v_lane[i]*64 +: 64] = {2'b01, 14'd0, v_ppa[i]};
            do_req(v_hppa[i], v_ppa[i], v_nh[i], 0, 0, 2'b00);
            checks++; if (cap_addr[0] !== v_addr[i]) begin failures++; $display("FAIL lane%0d_addr got=%h exp=%h", i, cap_addr[0], v_addr[i]); end
            checks++; if (cap_strb[0] !== v_strb[i]) begin failures++; $display("FAIL lane%0d_strb got=%h exp=%h", i, cap_strb[0], v_strb[i]); end
            checks++; if (cap_data[0] !== exp_d) begin failures++; $display("FAIL lane%0d_data got=%h exp=%h", i, cap_data[0], exp_d); end
            checks++; if (free_lst_head_o !== v_nh[i] || done_n !== 1) begin failures++; $display("FAIL lane%0d_head got=%0d/%0d exp=%0d/1", i, free_lst_head_o, done_n, v_nh[i]); end
        end
    endtask

    task automatic test_aw_delay();
        do_req(BASE + 48'd2, 48'h777, 6'd3, 3, 0, 2'b00);
        checks++; if (aw_hi !== 4) begin failures++; $display("FAIL awdly_aw_len got=%0d exp=4", aw_hi); end
        checks++; if (w_hi !== 1) begin failures++; $display("FAIL awdly_w_len got=%0d exp=1", w_hi); end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL awdly_stable got=%0d exp=0", unstable); end
        checks++; if (cap_addr[0] !== ATT || cap_strb[0] !== 64'h0000_0000_00FF_0000) begin failures++; $display("FAIL awdly_payload addr=%h strb=%h", cap_addr[0], cap_strb[0]); end
        checks++; if (done_n !== 1 || done_cyc !== LAT + 3) begin failures++; $display("FAIL awdly_done cnt=%0d cyc=%0d exp=1/%0d", done_n, done_cyc, LAT + 3); end
        checks++; if (free_lst_head_o !== 6'd3) begin failures++; $display("FAIL awdly_head got=%0d exp=3", free_lst_head_o); end
    endtask

    task automatic test_err();
        do_req(BASE + 48'd3, 48'h1, 6'd4, 0, 0, 2'b10);
        checks++; if (updt_err_o !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", updt_err_o); end
        checks++; if (free_lst_head_o !== 6'd4 || done_n !== 1) begin failures++; $display("FAIL err_head got=%0d/%0d exp=4/1", free_lst_head_o, done_n); end
        do_req(BASE + 48'd4, 48'h2, 6'd7, 0, 0, 2'b00);
        checks++; if (updt_err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", updt_err_o); end
        checks++; if (free_lst_head_o !== 6'd7) begin failures++; $display("FAIL err_head2 got=%0d exp=7", free_lst_head_o); end
    endtask

`ifdef HAWK_TBL_UPDT_LST_CLR_EN
    task automatic test_lst_clr();
        do_req(BASE + 48'd5, 48'h3, 6'd6, 0, 0, 2'b00);
        do_req(BASE + 48'd1, 48'h4, 6'd9, 0, 0, 2'b00);
        checks++; if (cap_addr[1] !== LST + 48'h40) begin failures++; $display("FAIL lst_addr got=%h exp=%h", cap_addr[1], LST + 48'h40); end
        checks++; if (cap_strb[1] !== 64'h0000_0000_FFFF_0000) begin failures++; $display("FAIL lst_strb got=%h exp=ffff0000", cap_strb[1]); end
        checks++; if (cap_data[1] !== 512'd0) begin failures++; $display("FAIL lst_data got=%h exp=0", cap_data[1]); end
        checks++; if (free_lst_head_o !== 6'd9 || done_n !== 1) begin failures++; $display("FAIL lst_head got=%0d/%0d exp=9/1", free_lst_head_o, done_n); end
    endtask
`endif

    task automatic test_reset_mid();
        @(negedge clk);
        awready_i = 1'b0; wready_i = 1'b0;
        hppa_i = BASE + 48'd8; ppa_i = 48'h99; nxt_head_i = 6'd12; updt_req_i = 1'b1;
        @(negedge clk);
        updt_req_i = 1'b0;
        checks++; if ({awvalid_o, wvalid_o} !== 2'b11) begin failures++; $display("FAIL mid_in_wr got=%b exp=11", {awvalid_o, wvalid_o}); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if ({awvalid_o, wvalid_o} !== 2'b00) begin failures++; $display("FAIL mid_async_drop got=%b exp=00", {awvalid_o, wvalid_o}); end
        @(negedge clk);
        rst_ni = 1'b1;
        awready_i = 1'b1; wready_i = 1'b1;
        @(negedge clk);
        checks++; if (free_lst_head_o !== 6'd1 || updt_rdy_o !== 1'b1) begin failures++; $display("FAIL mid_after_rst head=%0d rdy=%b exp=1/1", free_lst_head_o, updt_rdy_o); end
        do_req(BASE + 48'd9, 48'hABC, 6'd2, 0, 0, 2'b00);
        checks++; if (timeout !== 0 || done_n !== 1 || free_lst_head_o !== 6'd2) begin failures++; $display("FAIL mid_recover to=%0d done=%0d head=%0d exp=0/1/2", timeout, done_n, free_lst_head_o); end
        checks++; if (cap_addr[0] !== ATT + 48'h40) begin failures++; $display("FAIL mid_recover_addr got=%h exp=%h", cap_addr[0], ATT + 48'h40); end
    endtask

    task automatic test_stray_b();
        @(negedge clk);
        bvalid_i = 1'b1; bresp_i = 2'b11;
        repeat (2) @(negedge clk);
        bvalid_i = 1'b0; bresp_i = 2'b00;
        @(negedge clk);
        checks++; if (updt_err_o !== 1'b0 || bready_o !== 1'b0) begin failures++; $display("FAIL stray_b err=%b bready=%b exp=0/0", updt_err_o, bready_o); end
        checks++; if (updt_rdy_o !== 1'b1 || updt_done_o !== 1'b0) begin failures++; $display("FAIL stray_b_state rdy=%b done=%b exp=1/0", updt_rdy_o, updt_done_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lanes();
        test_aw_delay();
        test_err();
`ifdef HAWK_TBL_UPDT_LST_CLR_EN
        test_lst_clr();
`endif
        test_reset_mid();
        test_stray_b();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
